// File: rtl/timer_entry_pkg.sv
// Shared types and constants for the microwave timer keypad entry block.
package timer_entry_pkg;
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } fsm_state_t;

   localparam int         BCD_W        = 4;
   localparam logic [3:0] KEY_BACK     = 4'hA;
   localparam logic [3:0] KEY_CLEAR    = 4'hB;
   localparam logic [3:0] KEY_NONE     = 4'hF;
   localparam logic [3:0] SEC_TENS_MAX = 4'd5;
endpackage

// File: rtl/keypad_debounce.sv
// Keypad priority encoder and debounce FSM; pulses key_accept once per press.
// state    | meaning
// IDLE     | no key seen, waiting for a non-NONE code
// DEBOUNCE | counting consecutive identical samples of cand
// HELD     | key accepted, waiting for full release
module keypad_debounce
   import timer_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] switches,
   input  logic       clear_key,
   input  logic       back_key,
   output logic [3:0] key_code,
   output logic       key_accept
);
   localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES);

   fsm_state_t state, state_nxt;
   logic [3:0] cand, cand_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic [3:0] code;

   // Ascending scan so the highest asserted digit key wins.
   always_comb begin
      code = KEY_NONE;
      if (clear_key) begin
         code = KEY_CLEAR;
      end else if (back_key) begin
         code = KEY_BACK;
      end else begin
         for (int i = 0; i < 10; i++) begin
            if (switches[i]) code = 4'(i);
         end
      end
   end

   assign key_code = code;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cand  <= KEY_NONE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cand  <= cand_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cand_nxt   = cand;
      cnt_nxt    = cnt;
      key_accept = 1'b0;
      case (state)
         IDLE: begin
            if (code != KEY_NONE) begin
               cand_nxt = code;
               if (CNT_LAST == 8'd1) begin
                  key_accept = 1'b1;
                  state_nxt  = HELD;
                  cnt_nxt    = '0;
               end else begin
                  cnt_nxt   = 8'd1;
                  state_nxt = DEBOUNCE;
               end
            end
         end
         DEBOUNCE: begin
            if (code == KEY_NONE) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (code != cand) begin
               cand_nxt = code;
               cnt_nxt  = 8'd1;
            end else if (cnt + 8'd1 == CNT_LAST) begin
               key_accept = 1'b1;
               state_nxt  = HELD;
               cnt_nxt    = '0;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         HELD: begin
            if (code == KEY_NONE) state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end
endmodule

// File: rtl/timer_entry.sv
// Keypad digit entry: shifts debounced BCD digits into the timer load register
// with clear, backspace, lock gating and seconds/minutes tens validity.
module timer_entry
   import timer_entry_pkg::*;
#(
   parameter int NUM_DIGITS      = 4,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [9:0]                         switches,
   input  logic                               clear_key,
   input  logic                               back_key,
   input  logic                               lock,
   output logic [BCD_W*NUM_DIGITS-1:0]        digits,
   output logic [$clog2(NUM_DIGITS+1)-1:0]    digit_count,
   output logic                               loadn,
   output logic                               time_valid,
   output logic                               key_strobe
);
   localparam int             CW         = $clog2(NUM_DIGITS + 1);
   localparam int             DW         = BCD_W * NUM_DIGITS;
   localparam logic [CW-1:0]  COUNT_FULL = CW'(NUM_DIGITS);

   logic [3:0] key_code;
   logic       key_accept;
   logic       apply;
   logic       tens_min_ok;

   keypad_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk        (clk),
      .rst        (rst),
      .switches   (switches),
      .clear_key  (clear_key),
      .back_key   (back_key),
      .key_code   (key_code),
      .key_accept (key_accept)
   );

   assign apply = key_accept & ~lock;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digits      <= '0;
         digit_count <= '0;
         loadn       <= 1'b0;
         key_strobe  <= 1'b0;
      end else begin
         key_strobe <= apply;
         if (apply) begin
            if (key_code == KEY_CLEAR) begin
               digits      <= '0;
               digit_count <= '0;
               loadn       <= 1'b0;
            end else if (key_code == KEY_BACK) begin
               digits <= {{BCD_W{1'b0}}, digits[DW-1:BCD_W]};
               if (digit_count != '0) begin
                  digit_count <= digit_count - 1'b1;
                  loadn       <= (digit_count != CW'(1));
               end
            end else if (key_code <= 4'd9 && digit_count != COUNT_FULL) begin
               // A full register drops further digits rather than recycling.
               digits      <= {digits[DW-BCD_W-1:0], key_code};
               digit_count <= digit_count + 1'b1;
               loadn       <= 1'b1;
            end
         end
      end
   end

   generate
      if (NUM_DIGITS >= 4) begin : g_min_tens
         assign tens_min_ok = (digits[4*BCD_W-1:3*BCD_W] <= SEC_TENS_MAX);
      end else begin : g_no_min_tens
         assign tens_min_ok = 1'b1;
      end
   endgenerate

   assign time_valid = (digits[2*BCD_W-1:BCD_W] <= SEC_TENS_MAX) && tens_min_ok;
endmodule

// File: tb/tb_timer_entry.sv
// Scoreboard bench for timer_entry: expected register state is queued per press
// and compared when key_strobe appears, including its arrival cycle.
module tb_timer_entry;
   localparam int DC = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  switches;
   logic        clear_key, back_key, lock;
   logic [15:0] digits;
   logic [2:0]  digit_count;
   logic        loadn, time_valid, key_strobe;

   typedef struct {
      logic [15:0] d;
      logic [2:0]  c;
      logic        l;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        e_pop, e_push;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          strobes = 0;
   int          s0;
   logic [15:0] m_d;
   logic [2:0]  m_c;
   logic        m_l;

   timer_entry #(.NUM_DIGITS(4), .DEBOUNCE_CYCLES(DC)) dut (
      .clk         (clk),
      .rst         (rst),
      .switches    (switches),
      .clear_key   (clear_key),
      .back_key    (back_key),
      .lock        (lock),
      .digits      (digits),
      .digit_count (digit_count),
      .loadn       (loadn),
      .time_valid  (time_valid),
      .key_strobe  (key_strobe)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [9:0] sw_of(input int d);
      logic [9:0] one;
      one = 10'd1;
      return one << d;
   endfunction

   always @(negedge clk) begin
      if (!rst && key_strobe) begin
         strobes++;
         chk("strobe_expected", (sb.size() != 0), 1);
         if (sb.size() != 0) begin
            e_pop = sb.pop_front();
            chk("sb_digits", digits, e_pop.d);
            chk("sb_count", digit_count, e_pop.c);
            chk("sb_loadn", loadn, e_pop.l);
            chk("sb_cycle", cyc, e_pop.cyc);
         end
      end
   end

   // Reference model of the entry register, advanced when an accept is expected.
   task automatic expect_key(input logic [3:0] code);
      if (code <= 4'd9) begin
         if (m_c < 3'd4) begin
            m_d = {m_d[11:0], code};
            m_c = m_c + 3'd1;
            m_l = 1'b1;
         end
      end else if (code == 4'hA) begin
         m_d = {4'h0, m_d[15:4]};
         if (m_c != 3'd0) m_c = m_c - 3'd1;
         m_l = (m_c != 3'd0);
      end else begin
         m_d = '0;
         m_c = '0;
         m_l = 1'b0;
      end
      e_push.d   = m_d;
      e_push.c   = m_c;
      e_push.l   = m_l;
      e_push.cyc = cyc + DC;
      sb.push_back(e_push);
   endtask

   // Called and returns at a falling edge; key is sampled on `hold` rising edges.
   task automatic press(input logic [9:0] sw, input logic clr, input logic bk,
                        input logic [3:0] code, input bit accept, input int hold, input int idle);
      if (accept) expect_key(code);
      switches  = sw;
      clear_key = clr;
      back_key  = bk;
      repeat (hold) @(negedge clk);
      switches  = '0;
      clear_key = 1'b0;
      back_key  = 1'b0;
      repeat (idle) @(negedge clk);
   endtask

   task automatic digit(input int d);
      press(sw_of(d), 1'b0, 1'b0, 4'(d), 1'b1, 6, 2);
   endtask

   task automatic do_clear();
      press('0, 1'b1, 1'b0, 4'hB, 1'b1, 6, 2);
   endtask

   task automatic do_back();
      press('0, 1'b0, 1'b1, 4'hA, 1'b1, 6, 2);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d limit reached", cyc);
      $fatal(1);
   end

   initial begin
      rst = 1'b1; switches = '0; clear_key = 1'b0; back_key = 1'b0; lock = 1'b0;
      m_d = '0; m_c = '0; m_l = 1'b0;
      #3;
      chk("rst_digits", digits, 16'h0);
      chk("rst_count", digit_count, 0);
      chk("rst_loadn", loadn, 0);
      chk("rst_strobe", key_strobe, 0);
      chk("rst_tv", time_valid, 1);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);

      s0 = strobes;
      digit(1); digit(2); digit(3); digit(0);
      chk("entry_digits", digits, 16'h1230);
      chk("entry_count", digit_count, 4);
      chk("entry_loadn", loadn, 1);
      chk("entry_strobes", strobes - s0, 4);

      s0 = strobes;
      digit(9);
      chk("full_digits", digits, 16'h1230);
      chk("full_count", digit_count, 4);
      chk("full_strobes", strobes - s0, 1);

      do_clear();
      s0 = strobes;
      press(sw_of(5), 1'b0, 1'b0, 4'd5, 1'b0, 2, 0);
      press(sw_of(7), 1'b0, 1'b0, 4'd7, 1'b0, 2, 0);
      press(sw_of(5), 1'b0, 1'b0, 4'd5, 1'b1, 4, 2);
      chk("bounce_digits", digits, 16'h0005);
      chk("bounce_count", digit_count, 1);
      chk("bounce_strobes", strobes - s0, 1);
      s0 = strobes;
      press(sw_of(8), 1'b0, 1'b0, 4'd8, 1'b0, 3, 2);
      chk("short8_nostrobe", strobes - s0, 0);
      chk("short8_digits", digits, 16'h0005);

      do_clear();
      digit(7); digit(4); digit(5); do_back();
      chk("back1_digits", digits, 16'h0074);
      chk("back1_count", digit_count, 2);
      do_back(); do_back(); do_back();
      chk("back3_digits", digits, 16'h0);
      chk("back3_count", digit_count, 0);
      chk("back3_loadn", loadn, 0);
      press(sw_of(6), 1'b1, 1'b0, 4'hB, 1'b1, 6, 2);
      chk("clr6_digits", digits, 16'h0);
      chk("clr6_count", digit_count, 0);

      digit(1); digit(8); digit(0);
      chk("tv_digits", digits, 16'h0180);
      chk("tv_invalid", time_valid, 0);
      do_clear();
      chk("tv_valid", time_valid, 1);
      chk("tv_loadn", loadn, 0);

      digit(4); digit(2);
      s0 = strobes;
      lock = 1'b1;
      switches = sw_of(3);
      repeat (6) @(negedge clk);
      lock = 1'b0;
      repeat (6) @(negedge clk);
      switches = '0;
      repeat (2) @(negedge clk);
      chk("lock_digits", digits, 16'h0042);
      chk("lock_count", digit_count, 2);
      chk("lock_strobes", strobes - s0, 0);

      chk("pre_rst_sb_empty", sb.size(), 0);
      switches = sw_of(7);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_digits", digits, 16'h0);
      chk("arst_count", digit_count, 0);
      chk("arst_loadn", loadn, 0);
      chk("arst_tv", time_valid, 1);
      m_d = '0; m_c = '0; m_l = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      s0 = strobes;
      press(sw_of(7), 1'b0, 1'b0, 4'd7, 1'b1, 6, 2);
      chk("post_rst_digits", digits, 16'h0007);
      chk("post_rst_strobes", strobes - s0, 1);

      repeat (4) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
